riscv_prefetch_ctrl: RTL and testbench

- Sequences the instruction-fetch side of the fetch FIFO.
- Issues word-aligned requests on the instruction memory port and tracks outstanding transactions.
- Pushes returned words into the FIFO with the correct fetch address, including unaligned branch targets.
- On branch: clears the FIFO and squashes in-flight responses so no stale word is ever pushed.

---
 rtl/riscv_prefetch_pkg.sv | 8 +
 rtl/riscv_prefetch_outstanding_cnt.sv | 39 +++
 rtl/riscv_prefetch_ctrl.sv | 83 ++++++++
 tb/tb_riscv_prefetch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_prefetch_pkg.sv
// riscv_prefetch_pkg: shared state encoding and address helpers for the prefetch controller
package riscv_prefetch_pkg;
  typedef enum logic {IDLE, REQ} prefetch_state_e;
  localparam logic [31:0] WORD_INC = 32'h4;
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/riscv_prefetch_outstanding_cnt.sv
// riscv_prefetch_outstanding_cnt: saturating outstanding-request counter plus discard counter
module riscv_prefetch_outstanding_cnt #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_discard,
  input  logic             discard_inc,
  output logic             dec_ok,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             discard_nz
);
  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_OUTSTANDING);
  logic [CNT_W:0] sum;
  logic [CNT_W-1:0] discard, discard_next;
  // next counts; a response with nothing outstanding is ignored, a branch reloads discard
  always_comb begin
    dec_ok = dec && cnt != '0;
    discard_nz = discard != '0;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc) - (CNT_W+1)'(dec_ok);
    cnt_next = sum > MAX_W ? MAX_W[CNT_W-1:0] : sum[CNT_W-1:0];
    discard_next = load_discard ? cnt_next :
                   discard + CNT_W'(discard_inc) - CNT_W'(dec_ok && discard_nz);
  end
  // counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      discard <= '0;
    end else begin
      cnt <= cnt_next;
      discard <= discard_next;
    end
  end
endmodule

// File: rtl/riscv_prefetch_ctrl.sv
// riscv_prefetch_ctrl: instruction prefetch sequencer feeding the fetch FIFO; DIFT_TAG_EN adds response tag passthrough
module riscv_prefetch_ctrl
  import riscv_prefetch_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
`ifdef DIFT_TAG_EN
  input  logic [3:0]  instr_rtag_i,
  output logic [3:0]  fifo_rtag_o,
`endif
  output logic        busy_o
);
  prefetch_state_e state_q;
  logic [31:0] fetch_addr_q, resp_addr_q, pend_addr_q;
  logic pend_q, gnt_ok, wait_gnt, issue, push, dec_ok, discard_nz;
  logic [CNT_W-1:0] cnt, cnt_next;

  riscv_prefetch_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(gnt_ok),
    .dec(instr_rvalid_i),
    .load_discard(branch_i),
    .discard_inc(gnt_ok && pend_q),
    .dec_ok(dec_ok),
    .cnt(cnt),
    .cnt_next(cnt_next),
    .discard_nz(discard_nz)
  );

  // issue decision uses the count after this cycle's grant/response so the limit is never overrun
  always_comb begin
    gnt_ok = state_q == REQ && instr_gnt_i;
    wait_gnt = state_q == REQ && !instr_gnt_i;
    issue = fetch_en_i && fifo_ready_i && cnt_next < CNT_W'(MAX_OUTSTANDING);
    push = dec_ok && !discard_nz && !branch_i && !rst;
    instr_req_o = state_q == REQ;
    instr_addr_o = instr_req_o ? word_align(fetch_addr_q) : '0;
    busy_o = cnt != '0 || instr_req_o;
    fifo_clear_o = branch_i && !rst;
    fifo_valid_o = push;
    fifo_addr_o = push ? resp_addr_q : '0;
    fifo_rdata_o = push ? instr_rdata_i : '0;
`ifdef DIFT_TAG_EN
    fifo_rtag_o = push ? instr_rtag_i : '0;
`endif
  end

  // request FSM and address tracking; a branch during an ungranted request is parked until its grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_addr_q <= '0;
      resp_addr_q <= '0;
      pend_addr_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= wait_gnt || issue ? REQ : IDLE;
      resp_addr_q <= branch_i ? branch_addr_i : push ? word_align(resp_addr_q) + WORD_INC : resp_addr_q;
      pend_q <= branch_i ? wait_gnt : pend_q && !instr_gnt_i;
      pend_addr_q <= branch_i ? branch_addr_i : pend_addr_q;
      fetch_addr_q <= branch_i ? (wait_gnt ? fetch_addr_q : word_align(branch_addr_i)) :
                      gnt_ok ? (pend_q ? word_align(pend_addr_q) : fetch_addr_q + WORD_INC) :
                      fetch_addr_q;
    end
  end
endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// tb_riscv_prefetch_ctrl: directed bench with a transaction-queue reference model
module tb_riscv_prefetch_ctrl;
  localparam int MAX = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 0, rst = 1, fetch_en_i = 0, branch_i = 0, fifo_ready_i = 1;
  logic instr_gnt_i = 0, instr_rvalid_i = 0;
  logic [31:0] branch_addr_i = 0, instr_rdata_i = 0;
  logic fifo_clear_o, fifo_valid_o, instr_req_o, busy_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;
`ifdef DIFT_TAG_EN
  logic [3:0] instr_rtag_i = 0, fifo_rtag_o;
`endif

  always #5 clk = ~clk;

  riscv_prefetch_ctrl #(.MAX_OUTSTANDING(MAX), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fifo_ready_i(fifo_ready_i),
    .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o),
    .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
`ifdef DIFT_TAG_EN
    .instr_rtag_i(instr_rtag_i), .fifo_rtag_o(fifo_rtag_o),
`endif
    .busy_o(busy_o)
  );

  int total = 0, bad = 0, nclr = 0;
  logic gnt_en = 1, rv_en = 1, stray = 0;
  logic [31:0] mq[$], glog[$], plog[$], dlog[$];

  typedef struct packed {logic [31:0] a; logic s;} ent_t;
  ent_t q[$];
  logic m_req = 0, m_pend = 0;
  logic [31:0] m_fetch = 0, m_pend_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // memory: grants whenever enabled, answers in order one cycle after the grant at the earliest
  always @(posedge clk) begin
    #1;
    instr_gnt_i = gnt_en && instr_req_o;
    if (rv_en && mq.size() > 0) begin
      instr_rvalid_i = 1;
      instr_rdata_i = mq.pop_front() ^ KEY;
    end else if (stray) begin
      instr_rvalid_i = 1;
      instr_rdata_i = 32'hDEAD_BEEF;
    end else begin
      instr_rvalid_i = 0;
      instr_rdata_i = 0;
    end
  end

  // reference model: a queue of in-flight requests, each tagged stale when a branch overtakes it
  always @(negedge clk) begin : model
    logic rv_ok, push, gnt_ok;
    if (rst) begin
      q.delete(); mq.delete();
      m_req = 0; m_pend = 0; m_fetch = 0; m_pend_addr = 0;
    end else begin
      rv_ok = instr_rvalid_i && q.size() > 0;
      push = rv_ok && !q[0].s && !branch_i;
      check("req", 32'(instr_req_o), 32'(m_req));
      if (m_req) check("req_addr", instr_addr_o, m_fetch & ~32'h3);
      check("busy", 32'(busy_o), 32'(q.size() != 0 || m_req));
      check("clear", 32'(fifo_clear_o), 32'(branch_i));
      check("valid", 32'(fifo_valid_o), 32'(push));
      if (push) begin
        check("push_addr", fifo_addr_o, q[0].a);
        check("push_data", fifo_rdata_o, instr_rdata_i);
      end
      if (instr_req_o && instr_gnt_i) begin
        mq.push_back(instr_addr_o);
        glog.push_back(instr_addr_o);
      end
      if (fifo_valid_o) begin
        plog.push_back(fifo_addr_o);
        dlog.push_back(fifo_rdata_o);
      end
      if (fifo_clear_o) nclr++;
      gnt_ok = m_req && instr_gnt_i;
      if (rv_ok) void'(q.pop_front());
      if (gnt_ok) begin
        q.push_back('{a: m_fetch, s: m_pend});
        if (m_pend) begin
          m_fetch = m_pend_addr;
          m_pend = 0;
        end else m_fetch = (m_fetch & ~32'h3) + 32'h4;
      end
      if (branch_i) begin
        foreach (q[i]) q[i].s = 1;
        if (m_req && !instr_gnt_i) begin
          m_pend = 1;
          m_pend_addr = branch_addr_i;
        end else begin
          m_fetch = branch_addr_i;
          m_pend = 0;
        end
      end
      m_req = (m_req && !instr_gnt_i) || (fetch_en_i && fifo_ready_i && q.size() < MAX);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic br(input logic [31:0] a);
    branch_i = 1;
    branch_addr_i = a;
    cyc();
    branch_i = 0;
  endtask

  task automatic clr();
    glog.delete(); plog.delete(); dlog.delete();
    nclr = 0;
  endtask

  task automatic drain();
    int n = 0;
    fetch_en_i = 0; branch_i = 0; gnt_en = 1; rv_en = 1; fifo_ready_i = 1; stray = 0;
    while (busy_o && n < 50) begin
      cyc();
      n++;
    end
    check("drain_idle", 32'(busy_o), 0);
    cyc();
  endtask

  initial begin
    repeat (3) cyc();
    rst = 0;
    check("rst_req", 32'(instr_req_o), 0);
    check("rst_addr", instr_addr_o, 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_valid", 32'(fifo_valid_o), 0);
    check("rst_clear", 32'(fifo_clear_o), 0);
    drain();

    clr(); fetch_en_i = 1; br(32'h100); repeat (6) cyc(); drain();
    check("lin_g0", glog[0], 32'h100);
    check("lin_g1", glog[1], 32'h104);
    check("lin_g2", glog[2], 32'h108);
    check("lin_p0", plog[0], 32'h100);
    check("lin_p1", plog[1], 32'h104);
    check("lin_p2", plog[2], 32'h108);
    check("lin_d0", dlog[0], 32'h100 ^ KEY);

    clr(); fetch_en_i = 1; br(32'h202); repeat (4) cyc(); drain();
    check("ua_g0", glog[0], 32'h200);
    check("ua_p0", plog[0], 32'h202);
    check("ua_p1", plog[1], 32'h204);

    clr(); rv_en = 0; fetch_en_i = 1; br(32'h300); repeat (5) cyc();
    check("b2_issued", glog.size(), 2);
    check("b2_req_lim", 32'(instr_req_o), 0);
    nclr = 0;
    br(32'h400); rv_en = 1; repeat (8) cyc();
    check("b2_clr_once", nclr, 1);
    drain();
    check("b2_p0", plog[0], 32'h400);
    check("b2_d0", dlog[0], 32'h400 ^ KEY);

    clr(); gnt_en = 0; fetch_en_i = 1; br(32'h10); cyc();
    check("bw_req", 32'(instr_req_o), 1);
    check("bw_addr0", instr_addr_o, 32'h10);
    br(32'h80);
    check("bw_addr1", instr_addr_o, 32'h10);
    gnt_en = 1; repeat (6) cyc(); drain();
    check("bw_g0", glog[0], 32'h10);
    check("bw_g1", glog[1], 32'h80);
    check("bw_p0", plog[0], 32'h80);

    clr(); rv_en = 0; fetch_en_i = 1; br(32'h500); repeat (4) cyc();
    fifo_ready_i = 0; rv_en = 1; repeat (5) cyc();
    check("bp_noreq", 32'(instr_req_o), 0);
    check("bp_npush", plog.size(), 2);
    check("bp_p0", plog[0], 32'h500);
    check("bp_p1", plog[1], 32'h504);
    fifo_ready_i = 1; cyc();
    check("bp_resume", 32'(instr_req_o), 1);
    drain();

    clr(); rv_en = 0; fetch_en_i = 1; br(32'h600); repeat (4) cyc();
    check("rs_busy", 32'(busy_o), 1);
    rst = 1; cyc(); rst = 0; fetch_en_i = 0; rv_en = 1;
    check("rs_req", 32'(instr_req_o), 0);
    check("rs_busy0", 32'(busy_o), 0);
    check("rs_valid", 32'(fifo_valid_o), 0);
    stray = 1; cyc();
    check("rs_stray", 32'(fifo_valid_o), 0);
    stray = 0; cyc();
    check("rs_sat", 32'(busy_o), 0);
    drain();

    clr(); rv_en = 0; fetch_en_i = 1; br(32'h700); repeat (4) cyc();
    branch_i = 1; branch_addr_i = 32'h740; cyc();
    branch_addr_i = 32'h780; cyc();
    branch_i = 0; rv_en = 1; repeat (8) cyc(); drain();
    check("bb_p0", plog[0], 32'h780);
    check("bb_clr", nclr, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
